// File: rtl/cdc_sync_bank.sv
// Multi-channel synchroniser into rd_clk: per-channel flop chain, optional stability filter,
// and rise/fall pulses derived from the filtered value. Channels are independent bits.
module cdc_sync_bank #(
  parameter int               WIDTH     = 4,
  parameter int               STAGES    = 2,
  parameter int               FILTER    = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             rd_clk,
  input  logic             rd_reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] rd_rise,
  output logic [WIDTH-1:0] rd_fall,
  output logic             rd_change
);

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("cdc_sync_bank: STAGES must be >= 2");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("cdc_sync_bank: WIDTH must be >= 1");
    end
  endgenerate

  // Pure flop chain: nothing may sit between these registers.
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] s_last;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge rd_clk or negedge rd_reset) begin
    if (!rd_reset) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= RESET_VAL;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s_last = sync_q[STAGES-1];

  generate
    if (FILTER == 0) begin : g_nofilt
      assign rd_data = s_last;
    end else begin : g_filt
      localparam int             CW      = $clog2(FILTER) + 1;
      localparam logic [CW-1:0] CNT_MAX = CW'(FILTER - 1);

      logic [CW-1:0]    cnt [WIDTH];
      logic [WIDTH-1:0] data_q;

      // A channel only follows s_last after FILTER consecutive differing cycles.
      always_ff @(posedge rd_clk or negedge rd_reset) begin
        if (!rd_reset) begin
          for (int c = 0; c < WIDTH; c++) cnt[c] <= '0;
          data_q <= RESET_VAL;
        end else begin
          for (int c = 0; c < WIDTH; c++) begin
            if (s_last[c] == data_q[c]) begin
              cnt[c] <= '0;
            end else if (cnt[c] == CNT_MAX) begin
              data_q[c] <= s_last[c];
              cnt[c]    <= '0;
            end else begin
              cnt[c] <= cnt[c] + CW'(1);
            end
          end
        end
      end

      assign rd_data = data_q;
    end
  endgenerate

  always_ff @(posedge rd_clk or negedge rd_reset) begin
    if (!rd_reset) prev_q <= RESET_VAL;
    else           prev_q <= rd_data;
  end

  assign rd_rise   = rd_data & ~prev_q;
  assign rd_fall   = ~rd_data & prev_q;
  assign rd_change = |(rd_rise | rd_fall);

endmodule

// File: tb/tb_cdc_sync_bank.sv
// Directed and randomised checks of cdc_sync_bank across three parameter sets:
// A (STAGES=3, no filter, RESET_VAL=1010), B (FILTER=4), C (FILTER=8).
module tb_cdc_sync_bank;

  typedef struct packed {
    logic [3:0] stim;
    logic [3:0] data;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       chg;
  } vec_t;

  logic       rd_clk   = 1'b0;
  logic       rd_reset = 1'b1;
  logic [3:0] in_a = 4'hF, in_b = 4'h0, in_c = 4'h0;
  logic [3:0] data_a, rise_a, fall_a, data_b, rise_b, fall_b, data_c, rise_c, fall_c;
  logic       chg_a, chg_b, chg_c;

  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   mon_err = 0;
  bit   mon_en  = 1'b0;
  logic [3:0] pa = 4'h0, pb = 4'h0;
  vec_t tbl [13];

  always #5 rd_clk = ~rd_clk;

  cdc_sync_bank #(.WIDTH(4), .STAGES(3), .FILTER(0), .RESET_VAL(4'b1010)) dut_a (
    .rd_clk(rd_clk), .rd_reset(rd_reset), .async_in(in_a),
    .rd_data(data_a), .rd_rise(rise_a), .rd_fall(fall_a), .rd_change(chg_a));

  cdc_sync_bank #(.WIDTH(4), .STAGES(2), .FILTER(4), .RESET_VAL(4'b0000)) dut_b (
    .rd_clk(rd_clk), .rd_reset(rd_reset), .async_in(in_b),
    .rd_data(data_b), .rd_rise(rise_b), .rd_fall(fall_b), .rd_change(chg_b));

  cdc_sync_bank #(.WIDTH(4), .STAGES(2), .FILTER(8), .RESET_VAL(4'b0000)) dut_c (
    .rd_clk(rd_clk), .rd_reset(rd_reset), .async_in(in_c),
    .rd_data(data_c), .rd_rise(rise_c), .rd_fall(fall_c), .rd_change(chg_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    @(negedge rd_clk);
  endtask

  // Pulse outputs must match transitions of rd_data seen by the bench.
  always @(negedge rd_clk) begin
    if (mon_en) begin
      if (rise_a !== (data_a & ~pa) || fall_a !== (~data_a & pa) ||
          chg_a !== (|((data_a & ~pa) | (~data_a & pa)))) mon_err++;
      if (rise_b !== (data_b & ~pb) || fall_b !== (~data_b & pb) ||
          chg_b !== (|((data_b & ~pb) | (~data_b & pb)))) mon_err++;
    end
    pa = data_a;
    pb = data_b;
  end

  initial begin
    logic [3:0] seen;
    logic [3:0] base;
    int fall_cnt, rise_cnt, fall_at;

    // stim, data (= stim two steps earlier), rise, fall, change for dut_a
    tbl[0]  = '{4'hF, 4'hF, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{4'hE, 4'hF, 4'h0, 4'h0, 1'b0};
    tbl[2]  = '{4'hE, 4'hF, 4'h0, 4'h0, 1'b0};
    tbl[3]  = '{4'hE, 4'hE, 4'h0, 4'h1, 1'b1};
    tbl[4]  = '{4'h7, 4'hE, 4'h0, 4'h0, 1'b0};
    tbl[5]  = '{4'h7, 4'hE, 4'h0, 4'h0, 1'b0};
    tbl[6]  = '{4'h7, 4'h7, 4'h1, 4'h8, 1'b1};
    tbl[7]  = '{4'h6, 4'h7, 4'h0, 4'h0, 1'b0};
    tbl[8]  = '{4'h7, 4'h7, 4'h0, 4'h0, 1'b0};
    tbl[9]  = '{4'h6, 4'h6, 4'h0, 4'h1, 1'b1};
    tbl[10] = '{4'h6, 4'h7, 4'h1, 4'h0, 1'b1};
    tbl[11] = '{4'h6, 4'h6, 4'h0, 4'h1, 1'b1};
    tbl[12] = '{4'h6, 4'h6, 4'h0, 4'h0, 1'b0};

    // Reset asserted before any clock edge: values must appear asynchronously.
    #1 rd_reset = 1'b0;
    #1;
    check("rst_async_data_a", data_a, 4'b1010);
    check("rst_async_data_b", data_b, 4'h0);
    check("rst_async_data_c", data_c, 4'h0);
    check("rst_async_pulses_a", {rise_a, fall_a}, 8'h00);
    check("rst_async_change_a", chg_a, 1'b0);
    tick();
    tick();
    check("rst_hold_data_a", data_a, 4'b1010);
    check("rst_hold_change_a", chg_a, 1'b0);

    rd_reset = 1'b1;
    tick();
    check("rel_e0_data_a", data_a, 4'b1010);
    tick();
    check("rel_e1_data_a", data_a, 4'b1010);
    tick();
    check("rel_e2_data_a", data_a, 4'hF);
    check("rel_e2_rise_a", rise_a, 4'b0101);
    check("rel_e2_fall_a", fall_a, 4'h0);
    check("rel_e2_change_a", chg_a, 1'b1);
    tick();
    check("rel_e3_rise_a", rise_a, 4'h0);
    check("rel_e3_change_a", chg_a, 1'b0);

    for (int k = 0; k < 13; k++) begin
      in_a = tbl[k].stim;
      tick();
      check($sformatf("vec%0d_data", k), data_a, tbl[k].data);
      check($sformatf("vec%0d_rise", k), rise_a, tbl[k].rise);
      check($sformatf("vec%0d_fall", k), fall_a, tbl[k].fall);
      check($sformatf("vec%0d_change", k), chg_a, tbl[k].chg);
    end

    // 3-cycle pulse on channel 1 must be rejected by FILTER=4.
    in_b = 4'b0010;
    seen = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | data_b | rise_b | fall_b | {3'b0, chg_b};
    end
    in_b = 4'h0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | data_b | rise_b | fall_b | {3'b0, chg_b};
    end
    check("glitch_reject_b", seen, 4'h0);

    // 6-cycle pulse: rd_data follows at E0+STAGES+3 = E0+5.
    in_b = 4'b0010;
    for (int i = 0; i < 5; i++) tick();
    check("long_e4_data_b", data_b, 4'h0);
    tick();
    check("long_e5_data_b", data_b, 4'b0010);
    check("long_e5_rise_b", rise_b, 4'b0010);
    check("long_e5_change_b", chg_b, 1'b1);
    in_b = 4'h0;
    tick();
    check("long_e6_rise_b", rise_b, 4'h0);
    check("long_e6_data_b", data_b, 4'b0010);
    fall_cnt = 0;
    rise_cnt = 0;
    fall_at  = -1;
    for (int i = 7; i <= 18; i++) begin
      tick();
      if (fall_b[1]) begin
        fall_cnt++;
        fall_at = i;
      end
      if (rise_b[1]) rise_cnt++;
    end
    check("long_fall_count_b", fall_cnt, 1);
    check("long_fall_edge_b", fall_at, 11);
    check("long_extra_rise_b", rise_cnt, 0);
    check("long_end_data_b", data_b, 4'h0);

    // FILTER=8: reset while cnt is 5, then the full count must restart.
    in_c = 4'b0001;
    for (int i = 0; i < 7; i++) tick();
    check("midcnt_data_c", data_c, 4'h0);
    rd_reset = 1'b0;
    #1;
    check("rst_mid_data_c", data_c, 4'h0);
    check("rst_mid_data_a", data_a, 4'b1010);
    tick();
    tick();
    rd_reset = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      tick();
      check($sformatf("refilter_e%0d_data_c", i), data_c, (i == 9) ? 4'b0001 : 4'b0000);
    end
    check("refilter_rise_c", rise_c, 4'b0001);
    check("refilter_change_c", chg_c, 1'b1);

    // Randomised asynchronous stimulus with short glitches and long holds.
    for (int i = 0; i < 20; i++) tick();
    mon_en = 1'b1;
    for (int it = 0; it < 500; it++) begin
      base = 4'($urandom_range(0, 15));
      in_a = base;
      in_b = base;
      #($urandom_range(0, 30));
      if ($urandom_range(0, 1) == 1) begin
        in_a = base ^ 4'($urandom_range(1, 15));
        in_b = in_a;
        #($urandom_range(3, 19));
        in_a = base;
        in_b = base;
      end
      #(140 + $urandom_range(0, 9));
      @(negedge rd_clk);
      check($sformatf("rand%0d_data_a", it), data_a, base);
      check($sformatf("rand%0d_data_b", it), data_b, base);
    end
    @(negedge rd_clk);
    mon_en = 1'b0;
    check("pulse_consistency", mon_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdc_sync_bank.md
# cdc_sync_bank

Parametrised multi-channel synchroniser for quasi-static and slow-toggling signals entering the `rd_clk` domain from any other clock domain or from asynchronous sources.

- Each channel passes through a configurable-depth flip-flop chain.
- An optional per-channel stability filter then rejects short glitches.
- Per-channel rise and fall pulses are produced from the filtered output.
- It replaces single-bit two-flop synchronisers wherever status bits, enables or interrupt lines cross into `rd_clk`.

## Interface
Parameters:
- `WIDTH`, 4: number of independent channels; must be ≥1.
- `STAGES`, 2: synchroniser flops per channel; must be ≥2 (elaboration error otherwise).
- `FILTER`, 0: stability filter length in `rd_clk` cycles.
  - 0 disables the filter.
  - N>0 requires the synchronised value to be stable for N consecutive cycles before `rd_data` follows it.
- `RESET_VAL`, 0: `WIDTH`-bit reset value of the sync chain and `rd_data`.

Ports:
- `rd_clk` input 1: destination clock. All state is clocked on `rd_clk` rising edge.
- `rd_reset` input 1: reset, asynchronous, active-low. Clock `rd_clk`.
- `async_in` input `WIDTH`: asynchronous inputs. No timing relationship to `rd_clk` is required.
- `rd_data` output `WIDTH`: synchronised (and filtered) channel values.
- `rd_rise` output `WIDTH`: one-cycle pulse per channel on a 0→1 change of `rd_data`.
- `rd_fall` output `WIDTH`: one-cycle pulse per channel on a 1→0 change of `rd_data`.
- `rd_change` output 1: OR of `rd_rise | rd_fall` across all channels.

## Operation
Sync chain:
- Per channel, `s[0]` samples `async_in`, and `s[i]` samples `s[i-1]`, up to `s[STAGES-1]` (`s_last`).
- No logic sits between chain flops. The chain registers carry the team's synchroniser attribute for placement and timing exclusion.

Filter, FILTER=0:
- `rd_data` is `s_last` directly; no counter is instantiated.

Filter, FILTER=N>0, per channel:
- Counter `cnt` of width clog2(N)+1.
- If `s_last == rd_data`: `cnt <= 0`.
- Else if `cnt == N-1`: `rd_data <= s_last` and `cnt <= 0`.
- Else: `cnt <= cnt + 1`.
- Any return of `s_last` to the current `rd_data` value before N consecutive differing cycles restarts the count. A pulse shorter than N cycles at `s_last` never reaches `rd_data`.

Edge detect:
- Register `prev <= rd_data` every cycle.
- `rd_rise = rd_data & ~prev`, `rd_fall = ~rd_data & prev`.
- Both are combinational from registers, so each pulse is exactly one cycle per `rd_data` transition.

Channels:
- Channels are fully independent. No multi-bit coherency is guaranteed across channels. Buses needing coherency must use the handshake or FIFO blocks instead.

Reset, `rd_reset` low, applied asynchronously:
- `s[*]`, `rd_data` and `prev` go to `RESET_VAL`.
- `cnt` goes to 0.
- Hence `rd_rise`, `rd_fall` and `rd_change` are 0 throughout reset.

Reset mid-operation:
- All state clears immediately, and any in-progress filter count is discarded.
- After deassertion, a channel whose `async_in` differs from `RESET_VAL` propagates normally and produces its edge pulse.

## Timing
- Input change captured at `rd_clk` edge E0 (`async_in` stable before E0):
  - `s_last` shows it after edge E0+STAGES-1.
  - `rd_data` shows it after edge E0+STAGES-1 when FILTER=0, or after edge E0+STAGES-1+N when FILTER=N.
- `rd_rise`/`rd_fall`/`rd_change` are high for the single cycle in which `rd_data` first holds the new value.
- Metastability: the first sample after an input change may resolve either way, so latency varies by ±1 cycle. Benches must accept either.
- Reset deassertion is expected to be synchronised externally to `rd_clk`. State is stable when `rd_reset` is low regardless of `rd_clk`.
- Back-to-back toggles:
  - With FILTER=0, each `s_last` change yields a pulse. Toggles at `rd_clk` rate give alternating rise/fall every cycle.
  - Input pulses narrower than one `rd_clk` period may be lost; this is permitted.

## Test plan
- Reset: WIDTH=4, RESET_VAL=4'b1010, hold `rd_reset` low with `async_in`=4'hF -> `rd_data`=4'b1010 and all pulses 0. Release -> `rd_data`=4'hF after STAGES(+FILTER) cycles, `rd_rise`=4'b0101 for one cycle.
- Latency: STAGES=3, FILTER=0, `async_in[0]` 0→1 synchronously before edge E0 -> `rd_data[0]`=1 after E0+2, `rd_rise[0]` and `rd_change` high exactly one cycle, `rd_fall`=0.
- Glitch rejection: FILTER=4, drive `async_in[1]` high for 3 `rd_clk` cycles -> `rd_data[1]` stays 0, no pulses. Then drive high for 6 cycles -> `rd_data[1]`=1 after STAGES+3 edges from capture, one `rd_rise[1]` pulse, followed later by one `rd_fall[1]` pulse.
- Independence: toggle channels 0 and 3 in the same cycle, with opposite directions -> `rd_rise[0]` and `rd_fall[3]` in the same cycle, `rd_change` single-cycle. Channels 1 and 2 remain unchanged.
- Reset mid-count: FILTER=8, assert `rd_reset` at count 5 -> `cnt` cleared and `rd_data`=RESET_VAL. After release with input still changed -> full 8-cycle filter applies again.
- Random async: async-clock stimulus on all channels over 10k cycles, with a scoreboard allowing ±1 cycle latency -> every stable-≥FILTER change is reflected, and every `rd_data` transition has exactly one matching pulse.
